// File: rtl/all_types_pkg.sv
// Shared enums for the parity checker/generator pair.
package all_types_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_t;

  typedef enum logic {
    MSB = 1'b0,
    LSB = 1'b1
  } parity_pos_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pg_skid_buffer.sv
// Two-entry valid/ready skid buffer; ready is registered so it never depends on out_grant_i.
module pg_skid_buffer
  import all_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_grant_i
);

  skid_state_t           state_q;
  logic                  ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic                  accept;
  logic                  xfer;

  assign accept      = in_valid_i & ready_q;
  assign xfer        = out_valid_q & out_grant_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_data_q  <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_data_q <= in_data_i;
          end else if (accept) begin
            skid_data_q <= in_data_i;
            ready_q     <= 1'b0;
            state_q     <= FULL;
          end else if (xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (xfer) begin
            out_data_q <= skid_data_q;
            ready_q    <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          ready_q     <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parity_generator.sv
// Adds a parity bit to each payload, buffers it for the FIFO push port and counts sent words.
module parity_generator
  import all_types_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH        = 8,
  parameter parity_mode_t PARITY_MODE       = EVEN,
  parameter parity_pos_t  PARITY_BIT_CHOICE = MSB,
  parameter int unsigned  CNT_WIDTH         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-2:0] data_i,
  output logic                  ready_o,
  input  logic                  inject_err_i,
  output logic                  push_valid_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  input  logic                  push_grant_i,
  output logic [CNT_WIDTH-1:0]  words_sent_o
);

  logic                  inj_q;
  logic                  inj;
  logic                  parity;
  logic [DATA_WIDTH-1:0] word;
  logic                  accept;
  logic                  xfer;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign accept = valid_i & ready_o;
  assign xfer   = push_valid_o & push_grant_i;

  // A pulse in the same cycle as the accept corrupts that very word.
  assign inj    = inj_q | inject_err_i;
  assign parity = (^data_i) ^ logic'(PARITY_MODE) ^ inj;

  always_comb begin
    word = '0;
    if (PARITY_BIT_CHOICE == MSB) begin
      word = {parity, data_i};
    end else begin
      word = {data_i, parity};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        inj_q <= 1'b0;
      end else if (inject_err_i) begin
        inj_q <= 1'b1;
      end
      if (xfer) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign words_sent_o = cnt_q;

  pg_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (valid_i),
    .in_data_i  (word),
    .in_ready_o (ready_o),
    .out_valid_o(push_valid_o),
    .out_data_o (push_data_o),
    .out_grant_i(push_grant_i)
  );

endmodule

// File: tb/tb_parity_generator.sv
// Three configurations: EVEN/MSB main, ODD/LSB, and a 2-bit counter for wrap.
module tb_parity_generator;
  import all_types_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vi[3];
  logic [6:0] di[3];
  logic       ro[3];
  logic       ie[3];
  logic       pv[3];
  logic [7:0] pd[3];
  logic       pg[3];
  logic [15:0] ws[3];
  logic [15:0] ws0, ws1;
  logic [1:0]  ws2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  sbq[3][$];
  logic [15:0] mcnt[3];
  logic        minj[3];
  logic        held_v[3];
  logic [7:0]  held_d[3];

  always #5 clk = ~clk;

  parity_generator #(.DATA_WIDTH(8), .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(MSB),
                     .CNT_WIDTH(16)) dut_em (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[0]), .data_i(di[0]), .ready_o(ro[0]),
    .inject_err_i(ie[0]), .push_valid_o(pv[0]), .push_data_o(pd[0]),
    .push_grant_i(pg[0]), .words_sent_o(ws0)
  );

  parity_generator #(.DATA_WIDTH(8), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(LSB),
                     .CNT_WIDTH(16)) dut_ol (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[1]), .data_i(di[1]), .ready_o(ro[1]),
    .inject_err_i(ie[1]), .push_valid_o(pv[1]), .push_data_o(pd[1]),
    .push_grant_i(pg[1]), .words_sent_o(ws1)
  );

  parity_generator #(.DATA_WIDTH(8), .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(MSB),
                     .CNT_WIDTH(2)) dut_cw (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[2]), .data_i(di[2]), .ready_o(ro[2]),
    .inject_err_i(ie[2]), .push_valid_o(pv[2]), .push_data_o(pd[2]),
    .push_grant_i(pg[2]), .words_sent_o(ws2)
  );

  assign ws[0] = ws0;
  assign ws[1] = ws1;
  assign ws[2] = {14'd0, ws2};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [6:0] d, input logic odd, input logic lsb,
                                    input logic inj);
    logic p;
    p = (^d) ^ odd ^ inj;
    return lsb ? {d, p} : {p, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop on transfer, all sampled at the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        mcnt[k]   = '0;
        minj[k]   = 1'b0;
        held_v[k] = 1'b0;
      end else begin
        check($sformatf("cnt%0d", k), ws[k], mcnt[k]);
        if (held_v[k]) begin
          check($sformatf("hold_valid%0d", k), 16'(pv[k]), 16'd1);
          check($sformatf("hold_data%0d", k), 16'(pd[k]), 16'(held_d[k]));
        end
        held_v[k] = pv[k] && !pg[k];
        held_d[k] = pd[k];
        if (pv[k] && pg[k]) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("spurious%0d", k), 16'(sbq[k].size()), 16'd1);
          end else begin
            check($sformatf("word%0d", k), 16'(pd[k]), 16'(sbq[k].pop_front()));
          end
          if (k == 1) check("xor_odd", 16'(^pd[k]), 16'd1);
          mcnt[k] = (mcnt[k] + 16'd1) & ((k == 2) ? 16'h0003 : 16'hffff);
        end
        if (vi[k] && ro[k]) begin
          sbq[k].push_back(mk(di[k], k == 1, k == 1, minj[k] | ie[k]));
          minj[k] = 1'b0;
        end else if (ie[k]) begin
          minj[k] = 1'b1;
        end
      end
    end
  end

  logic [1:0] cw_exp[5];

  initial begin
    cw_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vi[k] = 1'b0; di[k] = '0; ie[k] = 1'b0; pg[k] = 1'b1;
    end
    tick();
    tick();
    check("rst_pv", 16'(pv[0]), 16'd0);
    check("rst_pd", 16'(pd[0]), 16'd0);
    check("rst_ws", ws[0], 16'd0);
    check("rst_ready", 16'(ro[0]), 16'd1);
    rst_n = 1'b1;

    // Basic EVEN/MSB, one-cycle latency
    vi[0] = 1'b1; di[0] = 7'h03;
    tick();
    check("em_03_valid", 16'(pv[0]), 16'd1);
    check("em_03", 16'(pd[0]), 16'h0003);
    di[0] = 7'h01;
    tick();
    check("em_01", 16'(pd[0]), 16'h0081);
    vi[0] = 1'b0;
    tick();
    check("em_ws2", ws[0], 16'd2);
    check("em_idle_pv", 16'(pv[0]), 16'd0);

    // Backpressure: grant low for three edges
    pg[0] = 1'b0; vi[0] = 1'b1; di[0] = 7'h10;
    tick();
    check("bp_ready1", 16'(ro[0]), 16'd1);
    di[0] = 7'h11;
    tick();
    check("bp_ready_full", 16'(ro[0]), 16'd0);
    di[0] = 7'h12;
    tick();
    check("bp_ready_hold", 16'(ro[0]), 16'd0);
    check("bp_head", 16'(pd[0]), 16'h0090);
    pg[0] = 1'b1;
    tick();
    check("bp_skid_out", 16'(pd[0]), 16'h0011);
    check("bp_ready_back", 16'(ro[0]), 16'd1);
    tick();
    check("bp_12", 16'(pd[0]), 16'h0012);
    di[0] = 7'h13;
    tick();
    check("bp_13", 16'(pd[0]), 16'h0093);
    vi[0] = 1'b0;
    tick();
    check("bp_ws", ws[0], 16'd6);

    // Inject in the accept cycle, then clean word
    ie[0] = 1'b1; vi[0] = 1'b1; di[0] = 7'h03;
    tick();
    ie[0] = 1'b0;
    check("inj_83", 16'(pd[0]), 16'h0083);
    tick();
    check("inj_clean", 16'(pd[0]), 16'h0003);
    vi[0] = 1'b0;
    tick();
    // Armed while idle, double pulse corrupts only one word
    ie[0] = 1'b1;
    tick();
    tick();
    ie[0] = 1'b0; vi[0] = 1'b1; di[0] = 7'h01;
    tick();
    check("inj_armed", 16'(pd[0]), 16'h0001);
    tick();
    check("inj_once", 16'(pd[0]), 16'h0081);
    vi[0] = 1'b0;
    tick();
    tick();

    // Asynchronous reset while FULL
    pg[0] = 1'b0; vi[0] = 1'b1; di[0] = 7'h20;
    tick();
    di[0] = 7'h21;
    tick();
    check("rf_full", 16'(ro[0]), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rf_pv", 16'(pv[0]), 16'd0);
    check("rf_ready", 16'(ro[0]), 16'd1);
    check("rf_ws", ws[0], 16'd0);
    di[0] = 7'h05;
    tick();
    rst_n = 1'b1; pg[0] = 1'b1;
    tick();
    check("rf_first_v", 16'(pv[0]), 16'd1);
    check("rf_first", 16'(pd[0]), 16'h0005);
    vi[0] = 1'b0;
    tick();
    check("rf_ws1", ws[0], 16'd1);

    // ODD/LSB
    vi[1] = 1'b1; di[1] = 7'h01;
    tick();
    check("ol_01", 16'(pd[1]), 16'h0002);
    di[1] = 7'h00;
    tick();
    check("ol_00", 16'(pd[1]), 16'h0001);
    vi[1] = 1'b0;
    tick();

    // Counter wrap at 2 bits
    vi[2] = 1'b1; di[2] = 7'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) di[2] = 7'(i + 1);
      else vi[2] = 1'b0;
      tick();
      check($sformatf("wrap%0d", i), ws[2], 16'(cw_exp[i]));
    end

    tick();
    tick();
    for (int k = 0; k < 3; k++) check($sformatf("drain%0d", k), 16'(sbq[k].size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
